// File: rtl/vm2_pkg.sv
// Shared types and default tables for the vending_machine_v2 slice.
package vm2_pkg;

    localparam int unsigned CODE_W      = 4;
    localparam int unsigned DEF_N_PROD  = 8;
    localparam int unsigned DEF_N_DENOM = 15;
    localparam int unsigned DEF_VAL_W   = 21;

    // Entry i-1 (counted from the LSB) belongs to code i.
    localparam logic [DEF_N_PROD*DEF_VAL_W-1:0] DEF_PRICE_TABLE = {
        21'd800, 21'd900, 21'd300, 21'd450, 21'd420, 21'd400, 21'd350, 21'd320
    };

    localparam logic [DEF_N_DENOM*DEF_VAL_W-1:0] DEF_DENOM_TABLE = {
        21'd1,    21'd2,     21'd5,     21'd10,    21'd25,
        21'd50,   21'd100,   21'd200,   21'd500,   21'd1000,
        21'd2000, 21'd5000,  21'd10000, 21'd20000, 21'd50000
    };

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_e;

endpackage

// File: rtl/vending_machine_v2_if.sv
// Coin acceptor / dispenser bus of the vending machine; master is the controller.
interface vending_machine_v2_if #(
    parameter int unsigned VAL_W = vm2_pkg::DEF_VAL_W
) ();

    logic [vm2_pkg::CODE_W-1:0] i_product_code;
    logic                       i_buy;
    logic                       i_cancel;
    logic [vm2_pkg::CODE_W-1:0] i_money;
    logic                       i_money_valid;
    logic                       i_product_ready;
    logic                       i_change_ack;
    logic [vm2_pkg::CODE_W-1:0] o_product_code;
    logic                       o_product_valid;
    logic                       o_busy;
    logic                       o_coin_reject;
    logic [vm2_pkg::CODE_W-1:0] o_change_code;
    logic                       o_change_valid;
    logic                       o_refund;
    logic                       o_no_change;
    logic [VAL_W-1:0]           o_shortfall;
    logic [VAL_W-1:0]           o_wallet;

    modport master (
        input  i_product_code, i_buy, i_cancel, i_money, i_money_valid,
               i_product_ready, i_change_ack,
        output o_product_code, o_product_valid, o_busy, o_coin_reject,
               o_change_code, o_change_valid, o_refund, o_no_change,
               o_shortfall, o_wallet
    );

    modport slave (
        output i_product_code, i_buy, i_cancel, i_money, i_money_valid,
               i_product_ready, i_change_ack,
        input  o_product_code, o_product_valid, o_busy, o_coin_reject,
               o_change_code, o_change_valid, o_refund, o_no_change,
               o_shortfall, o_wallet
    );

endinterface

// File: rtl/vm2_change_picker.sv
// Greedy change selector: highest-value non-empty denomination not exceeding the change.
module vm2_change_picker
    import vm2_pkg::*;
#(
    parameter int unsigned N_DENOM = DEF_N_DENOM,
    parameter int unsigned VAL_W   = DEF_VAL_W,
    parameter int unsigned CNT_W   = 16,
    parameter logic [N_DENOM*VAL_W-1:0] DENOM_TABLE = DEF_DENOM_TABLE
) (
    input  logic [VAL_W-1:0]                change_i,
    input  logic [N_DENOM-1:0][CNT_W-1:0]   tube_i,
    output logic                            sel_valid_o,
    output logic [CODE_W-1:0]               sel_code_o,
    output logic [VAL_W-1:0]                sel_value_o
);

    // Values descend with code, so the last hit of a downward scan is the largest coin.
    always_comb begin
        sel_valid_o = 1'b0;
        sel_code_o  = '0;
        sel_value_o = '0;
        for (int i = int'(N_DENOM) - 1; i >= 0; i--) begin
            if (tube_i[i] != '0 && DENOM_TABLE[i*VAL_W +: VAL_W] <= change_i) begin
                sel_valid_o = 1'b1;
                sel_code_o  = CODE_W'(i + 1);
                sel_value_o = DENOM_TABLE[i*VAL_W +: VAL_W];
            end
        end
    end

endmodule

// File: rtl/vending_machine_v2.sv
// Parametrised vending controller: order, coin collection, vend, change/refund dispensing.
module vending_machine_v2
    import vm2_pkg::*;
#(
    parameter int unsigned N_PROD      = DEF_N_PROD,
    parameter int unsigned N_DENOM     = DEF_N_DENOM,
    parameter int unsigned VAL_W       = DEF_VAL_W,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned INIT_CNT    = 100,
    parameter int unsigned MAX_CNT     = 2**CNT_W - 1,
    parameter logic [N_PROD*VAL_W-1:0]  PRICE_TABLE = DEF_PRICE_TABLE,
    parameter logic [N_DENOM*VAL_W-1:0] DENOM_TABLE = DEF_DENOM_TABLE,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter logic [N_DENOM*CNT_W-1:0] INIT_TABLE  = {N_DENOM{CNT_W'(INIT_CNT)}}
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    vending_machine_v2_if.master bus
);

    localparam int unsigned TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    state_e                       state_q, state_d;
    logic [CODE_W-1:0]            code_q, code_d;
    logic [VAL_W-1:0]             price_q, price_d;
    logic [VAL_W-1:0]             wallet_q, wallet_d;
    logic [VAL_W-1:0]             change_q, change_d;
    logic [N_DENOM-1:0][CNT_W-1:0] tube_q, tube_d;
    logic [TMO_W-1:0]             tmo_q, tmo_d;
    logic [CODE_W-1:0]            prod_code_q, prod_code_d;
    logic                         prod_valid_q, prod_valid_d;
    logic                         busy_q, busy_d;
    logic                         coin_reject_q, coin_reject_d;
    logic [CODE_W-1:0]            chg_code_q, chg_code_d;
    logic                         chg_valid_q, chg_valid_d;
    logic                         refund_q, refund_d;
    logic                         no_change_q, no_change_d;
    logic [VAL_W-1:0]             shortfall_q, shortfall_d;

    logic [VAL_W-1:0]             coin_val;
    logic                         coin_ok;
    logic                         accept;
    logic                         timeout;
    logic [VAL_W:0]               coin_sum;
    logic                         sel_valid;
    logic [CODE_W-1:0]            sel_code;
    logic [VAL_W-1:0]             sel_value;

    vm2_change_picker #(
        .N_DENOM     (N_DENOM),
        .VAL_W       (VAL_W),
        .CNT_W       (CNT_W),
        .DENOM_TABLE (DENOM_TABLE)
    ) u_picker (
        .change_i    (change_q),
        .tube_i      (tube_q),
        .sel_valid_o (sel_valid),
        .sel_code_o  (sel_code),
        .sel_value_o (sel_value)
    );

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        price_d       = price_q;
        wallet_d      = wallet_q;
        change_d      = change_q;
        tube_d        = tube_q;
        tmo_d         = tmo_q;
        chg_code_d    = chg_code_q;
        chg_valid_d   = chg_valid_q;
        refund_d      = refund_q;
        shortfall_d   = shortfall_q;
        coin_reject_d = 1'b0;
        no_change_d   = 1'b0;
        coin_val      = '0;
        coin_ok       = 1'b0;
        accept        = 1'b0;
        timeout       = 1'b0;

        // Coin lookup; a coin that would overflow the wallet is treated like a full tube.
        for (int k = 0; k < int'(N_DENOM); k++) begin
            if (bus.i_money == CODE_W'(k + 1)) begin
                coin_val = DENOM_TABLE[k*VAL_W +: VAL_W];
                coin_ok  = tube_q[k] < CNT_W'(MAX_CNT);
            end
        end
        coin_sum = {1'b0, wallet_q} + {1'b0, coin_val};
        coin_ok  = coin_ok && !coin_sum[VAL_W];

        case (state_q)
            IDLE: begin
                if (bus.i_buy && bus.i_product_code != '0
                    && 32'(bus.i_product_code) <= N_PROD) begin
                    code_d = bus.i_product_code;
                    for (int p = 0; p < int'(N_PROD); p++) begin
                        if (bus.i_product_code == CODE_W'(p + 1)) begin
                            price_d = PRICE_TABLE[p*VAL_W +: VAL_W];
                        end
                    end
                    shortfall_d = '0;
                    tmo_d       = '0;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.i_money_valid) begin
                    if (coin_ok) begin
                        accept   = 1'b1;
                        wallet_d = coin_sum[VAL_W-1:0];
                        for (int k = 0; k < int'(N_DENOM); k++) begin
                            if (bus.i_money == CODE_W'(k + 1)) begin
                                tube_d[k] = tube_q[k] + CNT_W'(1);
                            end
                        end
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                tmo_d   = accept ? '0 : tmo_q + TMO_W'(1);
                timeout = (TIMEOUT_CYC != 0) && !accept && (tmo_q == TMO_W'(TMO_LAST));
                if (bus.i_cancel || timeout) begin
                    if (wallet_d == '0) begin
                        state_d = IDLE;
                    end else begin
                        change_d = wallet_d;
                        refund_d = 1'b1;
                        state_d  = CHANGE;
                    end
                end else if (wallet_q >= price_q) begin
                    state_d = VEND;
                end
            end
            VEND: begin
                if (bus.i_product_ready) begin
                    change_d = wallet_q - price_q;
                    state_d  = CHANGE;
                end
            end
            CHANGE: begin
                // Exit decisions are taken only while no coin is being offered.
                if (chg_valid_q) begin
                    if (bus.i_change_ack) begin
                        change_d    = change_q - sel_value;
                        chg_valid_d = 1'b0;
                        chg_code_d  = '0;
                        for (int k = 0; k < int'(N_DENOM); k++) begin
                            if (sel_code == CODE_W'(k + 1)) begin
                                tube_d[k] = tube_q[k] - CNT_W'(1);
                            end
                        end
                    end
                end else if (change_q == '0) begin
                    wallet_d = '0;
                    refund_d = 1'b0;
                    state_d  = IDLE;
                end else if (sel_valid) begin
                    chg_valid_d = 1'b1;
                    chg_code_d  = sel_code;
                end else begin
                    no_change_d = 1'b1;
                    shortfall_d = change_q;
                    wallet_d    = '0;
                    refund_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        prod_valid_d = (state_d == VEND);
        prod_code_d  = (state_d == VEND) ? code_d : '0;
        busy_d       = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            code_q        <= '0;
            price_q       <= '0;
            wallet_q      <= '0;
            change_q      <= '0;
            tube_q        <= INIT_TABLE;
            tmo_q         <= '0;
            prod_code_q   <= '0;
            prod_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            chg_code_q    <= '0;
            chg_valid_q   <= 1'b0;
            refund_q      <= 1'b0;
            no_change_q   <= 1'b0;
            shortfall_q   <= '0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            price_q       <= price_d;
            wallet_q      <= wallet_d;
            change_q      <= change_d;
            tube_q        <= tube_d;
            tmo_q         <= tmo_d;
            prod_code_q   <= prod_code_d;
            prod_valid_q  <= prod_valid_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
            chg_code_q    <= chg_code_d;
            chg_valid_q   <= chg_valid_d;
            refund_q      <= refund_d;
            no_change_q   <= no_change_d;
            shortfall_q   <= shortfall_d;
        end
    end

    assign bus.o_product_code  = prod_code_q;
    assign bus.o_product_valid = prod_valid_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_coin_reject   = coin_reject_q;
    assign bus.o_change_code   = chg_code_q;
    assign bus.o_change_valid  = chg_valid_q;
    assign bus.o_refund        = refund_q;
    assign bus.o_no_change     = no_change_q;
    assign bus.o_shortfall     = shortfall_q;
    assign bus.o_wallet        = wallet_q;

endmodule

// File: tb/tb_vending_machine_v2.sv
// Directed bench: instance A (timeout 8) for the main flows, instance B with preset tubes.
module tb_vending_machine_v2;

    // Code 7 tube full, codes 10..15 empty, the rest at 100.
    localparam logic [15*16-1:0] B_INIT = {
        16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
        16'd100, 16'd100, 16'hFFFF,
        16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100
    };

    logic clk;
    logic rst;
    logic sel;
    logic [3:0] pcode, money;
    logic buy, cancel, mv, ready, ack;
    int n_tests;
    int n_fail;

    vending_machine_v2_if #(.VAL_W(21)) if_a ();
    vending_machine_v2_if #(.VAL_W(21)) if_b ();

    vending_machine_v2 #(.TIMEOUT_CYC(8)) u_a (.i_clk(clk), .i_rst(rst), .bus(if_a));
    vending_machine_v2 #(.INIT_TABLE(B_INIT)) u_b (.i_clk(clk), .i_rst(rst), .bus(if_b));

    assign if_a.i_product_code  = sel ? 4'd0 : pcode;
    assign if_a.i_buy           = ~sel & buy;
    assign if_a.i_cancel        = ~sel & cancel;
    assign if_a.i_money         = sel ? 4'd0 : money;
    assign if_a.i_money_valid   = ~sel & mv;
    assign if_a.i_product_ready = ~sel & ready;
    assign if_a.i_change_ack    = ~sel & ack;
    assign if_b.i_product_code  = sel ? pcode : 4'd0;
    assign if_b.i_buy           = sel & buy;
    assign if_b.i_cancel        = sel & cancel;
    assign if_b.i_money         = sel ? money : 4'd0;
    assign if_b.i_money_valid   = sel & mv;
    assign if_b.i_product_ready = sel & ready;
    assign if_b.i_change_ack    = sel & ack;

    logic [3:0]  o_pcode, o_ccode;
    logic        o_pvalid, o_busy, o_rej, o_cvalid, o_refund, o_noch;
    logic [20:0] o_short, o_wallet;
    assign o_pcode  = sel ? if_b.o_product_code  : if_a.o_product_code;
    assign o_pvalid = sel ? if_b.o_product_valid : if_a.o_product_valid;
    assign o_busy   = sel ? if_b.o_busy          : if_a.o_busy;
    assign o_rej    = sel ? if_b.o_coin_reject   : if_a.o_coin_reject;
    assign o_ccode  = sel ? if_b.o_change_code   : if_a.o_change_code;
    assign o_cvalid = sel ? if_b.o_change_valid  : if_a.o_change_valid;
    assign o_refund = sel ? if_b.o_refund        : if_a.o_refund;
    assign o_noch   = sel ? if_b.o_no_change     : if_a.o_no_change;
    assign o_short  = sel ? if_b.o_shortfall     : if_a.o_shortfall;
    assign o_wallet = sel ? if_b.o_wallet        : if_a.o_wallet;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return o_cvalid;
            1:       return !o_busy;
            default: return o_pvalid;
        endcase
    endfunction

    // 0: change offered, 1: back to idle, 2: product offered
    task automatic wait_for(input int which, input string tag);
        bit hit = 1'b0;
        for (int c = 0; c < 64 && !hit; c++) begin
            if (probe(which)) hit = 1'b1;
            else step();
        end
        if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic order(input logic [3:0] code);
        pcode = code;
        buy   = 1'b1;
        step();
        buy   = 1'b0;
    endtask

    task automatic ack_coin();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    logic [3:0] exp_codes [3];

    initial begin
        n_tests = 0; n_fail = 0;
        sel = 1'b0; pcode = '0; money = '0;
        buy = 1'b0; cancel = 1'b0; mv = 1'b0; ready = 1'b0; ack = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_wallet", 32'(o_wallet), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_pvalid", 32'(o_pvalid), 32'd0);
        check("rst_cvalid", 32'(o_cvalid), 32'd0);
        check("rst_tube_a", 32'(u_a.tube_q[0]), 32'd100);
        check("rst_tube_b_full", 32'(u_b.tube_q[6]), 32'd65535);

        // Buy code 1 (320), pay 2x200, change 80 = 50 + 25 + 5
        order(4'd1);
        money = 4'd8; mv = 1'b1;
        step(); step();
        mv = 1'b0;
        check("t1_wallet", 32'(o_wallet), 32'd400);
        check("t1_busy_collect", 32'(o_busy), 32'd0);
        step();
        check("t1_pvalid", 32'(o_pvalid), 32'd1);
        check("t1_pcode", 32'(o_pcode), 32'd1);
        step();
        check("t1_pvalid_hold", 32'(o_pvalid), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("t1_pvalid_drop", 32'(o_pvalid), 32'd0);
        check("t1_busy_change", 32'(o_busy), 32'd1);
        check("t1_tube8", 32'(u_a.tube_q[7]), 32'd102);
        exp_codes[0] = 4'd10; exp_codes[1] = 4'd11; exp_codes[2] = 4'd13;
        for (int i = 0; i < 3; i++) begin
            wait_for(0, "t1_coin");
            check($sformatf("t1_code%0d", i), 32'(o_ccode), 32'(exp_codes[i]));
            check($sformatf("t1_refund%0d", i), 32'(o_refund), 32'd0);
            if (i == 0) begin
                step(); step();
                check("t1_hold_code", 32'(o_ccode), 32'd10);
                check("t1_hold_valid", 32'(o_cvalid), 32'd1);
            end
            ack_coin();
        end
        wait_for(1, "t1_idle");
        check("t1_end_wallet", 32'(o_wallet), 32'd0);
        check("t1_end_short", 32'(o_short), 32'd0);

        // Buy code 3 (400), coin 100, then cancel with a coin in the same cycle
        order(4'd3);
        money = 4'd9; mv = 1'b1;
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0; mv = 1'b0;
        check("t2_refund", 32'(o_refund), 32'd1);
        check("t2_wallet", 32'(o_wallet), 32'd200);
        wait_for(0, "t2_coin");
        check("t2_code", 32'(o_ccode), 32'd8);
        check("t2_refund_hold", 32'(o_refund), 32'd1);
        ack_coin();
        wait_for(1, "t2_idle");
        check("t2_refund_clr", 32'(o_refund), 32'd0);
        check("t2_wallet_clr", 32'(o_wallet), 32'd0);

        // Invalid coin code 0, then cancel with an empty wallet
        order(4'd2);
        money = 4'd0; mv = 1'b1;
        step();
        mv = 1'b0;
        check("t3_reject", 32'(o_rej), 32'd1);
        check("t3_wallet", 32'(o_wallet), 32'd0);
        step();
        check("t3_reject_pulse", 32'(o_rej), 32'd0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("t3_cancel_busy", 32'(o_busy), 32'd0);
        // Invalid product code is ignored; a later coin must not be credited
        order(4'd9);
        money = 4'd9; mv = 1'b1;
        step();
        mv = 1'b0;
        step();
        check("t3_badcode_wallet", 32'(o_wallet), 32'd0);
        check("t3_badcode_reject", 32'(o_rej), 32'd0);

        // Timeout after 8 idle cycles refunds the single 100 coin
        order(4'd1);
        money = 4'd9; mv = 1'b1;
        step();
        mv = 1'b0;
        repeat (7) step();
        check("t4_busy_before", 32'(o_busy), 32'd0);
        step();
        check("t4_busy_after", 32'(o_busy), 32'd1);
        check("t4_refund", 32'(o_refund), 32'd1);
        wait_for(0, "t4_coin");
        check("t4_code", 32'(o_ccode), 32'd9);
        ack_coin();
        wait_for(1, "t4_idle");
        check("t4_wallet", 32'(o_wallet), 32'd0);

        // Reset while a change coin is offered and unacknowledged
        order(4'd1);
        money = 4'd7; mv = 1'b1;
        step();
        mv = 1'b0;
        wait_for(2, "t5_vend");
        ready = 1'b1;
        step();
        ready = 1'b0;
        wait_for(0, "t5_coin");
        check("t5_code", 32'(o_ccode), 32'd9);
        check("t5_tube7", 32'(u_a.tube_q[6]), 32'd101);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_cvalid", 32'(o_cvalid), 32'd0);
        check("t5_ccode", 32'(o_ccode), 32'd0);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_wallet", 32'(o_wallet), 32'd0);
        check("t5_tube7_init", 32'(u_a.tube_q[6]), 32'd100);
        check("t5_tube8_init", 32'(u_a.tube_q[7]), 32'd100);
        money = 4'd9; mv = 1'b1;
        step();
        mv = 1'b0;
        step();
        check("t5_idle_wallet", 32'(o_wallet), 32'd0);

        // Instance B: full tube rejection and impossible change
        sel = 1'b1;
        step();
        order(4'd1);
        money = 4'd7; mv = 1'b1;
        step();
        mv = 1'b0;
        check("b_full_reject", 32'(o_rej), 32'd1);
        check("b_full_wallet", 32'(o_wallet), 32'd0);
        money = 4'd8; mv = 1'b1;
        step(); step();
        mv = 1'b0;
        wait_for(2, "b_vend");
        ready = 1'b1;
        step();
        ready = 1'b0;
        wait_for(1, "b_idle");
        check("b_no_change", 32'(o_noch), 32'd1);
        check("b_shortfall", 32'(o_short), 32'd80);
        check("b_wallet", 32'(o_wallet), 32'd0);
        check("b_cvalid", 32'(o_cvalid), 32'd0);
        step();
        check("b_no_change_pulse", 32'(o_noch), 32'd0);
        check("b_shortfall_hold", 32'(o_short), 32'd80);
        order(4'd2);
        check("b_shortfall_clr", 32'(o_short), 32'd0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
